// File: rtl/alu_control_seq.sv
// alu_control_seq: ALU control decode plus mult/div iteration sequencer with stall and HI/LO write strobe.
// Optional abort input for in-flight mult/div when ALU_CTRL_ABORT_EN is defined.
module alu_control_seq #(
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 6,
  parameter int OP_W    = 4,
  localparam int CNT_W  = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
`ifdef ALU_CTRL_ABORT_EN
  input  logic               abort,
`endif
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [OP_W-1:0]    op,
  output logic               jr,
  output logic               stall,
  output logic [CNT_W-1:0]   step_idx,
  output logic               hilo_we,
  output logic               illegal
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_JR  = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] dec_op;
  logic dec_jr, dec_ill, dec_mul, dec_div, abort_i;
`ifdef ALU_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif
  always_comb begin
    dec_op  = OP_AND;
    dec_jr  = 1'b0;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    if (valid_in) begin
      case (alu_op)
        2'b00: dec_op = OP_ADD;
        2'b01: dec_op = OP_SUB;
        2'b11: dec_ill = 1'b1;
        default: begin
          case (funct)
            FUNCT_W'(6'b100000): dec_op = OP_ADD;
            FUNCT_W'(6'b100010): dec_op = OP_SUB;
            FUNCT_W'(6'b100100), FUNCT_W'(6'b001100): dec_op = OP_AND;
            FUNCT_W'(6'b100101), FUNCT_W'(6'b001101): dec_op = OP_OR;
            FUNCT_W'(6'b101010): dec_op = OP_SLT;
            FUNCT_W'(6'b001000): begin dec_op = OP_JR; dec_jr = 1'b1; end
            FUNCT_W'(6'b011000): begin dec_op = OP_ADD; dec_mul = 1'b1; end
            FUNCT_W'(6'b011010): begin dec_op = OP_SUB; dec_div = 1'b1; end
            default: dec_ill = 1'b1;
          endcase
        end
      endcase
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op       = OP_AND;
    jr       = 1'b0;
    stall    = 1'b0;
    step_idx = '0;
    hilo_we  = 1'b0;
    illegal  = 1'b0;
    if (state_q == MUL || state_q == DIV) begin
      stall    = 1'b1;
      op       = (state_q == MUL) ? OP_ADD : OP_SUB;
      step_idx = cnt_q;
      state_d  = abort_i ? IDLE : (cnt_q == LAST) ? DONE : state_q;
      cnt_d    = (abort_i || cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      op      = dec_op;
      jr      = dec_jr;
      illegal = dec_ill;
      hilo_we = (state_q == DONE);
      stall   = dec_mul | dec_div;
      state_d = dec_mul ? MUL : dec_div ? DIV : IDLE;
      cnt_d   = (dec_mul | dec_div) ? CNT_W'(1) : '0;
    end
    // Outputs are held quiet for the whole reset window, not just after the edge.
    if (!rst_n) begin
      op       = '0;
      jr       = 1'b0;
      stall    = 1'b0;
      step_idx = '0;
      hilo_we  = 1'b0;
      illegal  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: scoreboard bench with a cycle-level reference model of decode and mult/div sequencing.
module tb_alu_control_seq;
  localparam int DW = 8;
  localparam int CW = $clog2(DW);
  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0;
  logic [1:0] alu_op = '0;
  logic [5:0] funct = '0;
  logic [3:0] op;
  logic jr, stall, hilo_we, illegal;
  logic [CW-1:0] step_idx;
`ifdef ALU_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif
  always #5 clk = ~clk;
  alu_control_seq #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
`ifdef ALU_CTRL_ABORT_EN
    .abort(abort),
`endif
    .alu_op(alu_op), .funct(funct), .op(op), .jr(jr), .stall(stall),
    .step_idx(step_idx), .hilo_we(hilo_we), .illegal(illegal)
  );
  typedef struct packed {
    logic [3:0] op;
    logic jr, stall;
    logic [CW-1:0] step;
    logic hilo, ill;
  } exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0;
  int m_kind = 0, m_step = 0, m_hilo_total = 0, dut_hilo_total = 0;
  bit m_done = 0;
  logic [4:0] ftab [logic [5:0]];
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("op", int'(op), int'(e.op));
      check("jr", int'(jr), int'(e.jr));
      check("stall", int'(stall), int'(e.stall));
      check("step_idx", int'(step_idx), int'(e.step));
      check("hilo_we", int'(hilo_we), int'(e.hilo));
      check("illegal", int'(illegal), int'(e.ill));
      dut_hilo_total += int'(hilo_we);
    end
  end
  task automatic drive(input logic r, input logic v, input logic [1:0] a, input logic [5:0] f, input logic ab);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; valid_in = v; alu_op = a; funct = f;
`ifdef ALU_CTRL_ABORT_EN
    abort = ab;
`endif
    e = '0;
    if (!r) begin
      m_kind = 0;
      m_done = 0;
    end else if (m_kind != 0) begin
      e.stall = 1'b1;
      e.op = (m_kind == 1) ? 4'd2 : 4'd6;
      e.step = CW'(m_step);
`ifdef ALU_CTRL_ABORT_EN
      if (ab) m_kind = 0;
      else begin
`else
      begin
`endif
        m_step++;
        if (m_step == DW) begin
          m_kind = 0;
          m_done = 1;
        end
      end
    end else begin
      e.hilo = m_done;
      m_done = 0;
      if (v) begin
        if (a == 2'b00) e.op = 4'd2;
        else if (a == 2'b01) e.op = 4'd6;
        else if (a == 2'b11) e.ill = 1'b1;
        else if (f == 6'b011000 || f == 6'b011010) begin
          m_kind = (f == 6'b011000) ? 1 : 2;
          e.stall = 1'b1;
          e.op = (m_kind == 1) ? 4'd2 : 4'd6;
          m_step = 1;
        end else if (ftab.exists(f)) {e.jr, e.op} = ftab[f];
        else e.ill = 1'b1;
      end
    end
    m_hilo_total += int'(e.hilo);
    exp_q.push_back(e);
  endtask
  task automatic run(input logic [1:0] a, input logic [5:0] f, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, a, f, 1'b0);
  endtask
  initial begin
    logic [5:0] fl [10];
    ftab[6'b100000] = 5'b0_0010;
    ftab[6'b100010] = 5'b0_0110;
    ftab[6'b100100] = 5'b0_0000;
    ftab[6'b001100] = 5'b0_0000;
    ftab[6'b100101] = 5'b0_0001;
    ftab[6'b001101] = 5'b0_0001;
    ftab[6'b101010] = 5'b0_0111;
    ftab[6'b001000] = 5'b1_0011;
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
           6'b001000, 6'b011000, 6'b011010, 6'b111111, 6'b001101};
    drive(1'b0, 1'b1, 2'b10, 6'b011000, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 6'b011000, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 6'b000000, 1'b0);
    foreach (fl[i]) if (fl[i] != 6'b011000 && fl[i] != 6'b011010) run(2'b10, fl[i], 1);
    run(2'b00, 6'b011000, 1);
    run(2'b01, 6'b011010, 1);
    run(2'b11, 6'b100000, 1);
    drive(1'b1, 1'b0, 2'b10, 6'b011000, 1'b0);
    run(2'b10, 6'b011000, 1);
    for (int i = 0; i < DW - 1; i++) drive(1'b1, i[0], 2'(i), 6'($urandom), 1'b0);
    run(2'b10, 6'b011010, 1);
    for (int i = 0; i < DW - 1; i++) drive(1'b1, 1'b1, 2'b10, 6'b011000, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 6'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 6'b0, 1'b0);
    run(2'b10, 6'b011010, 3);
    drive(1'b0, 1'b1, 2'b10, 6'b011010, 1'b0);
    run(2'b00, 6'b000000, 2);
`ifdef ALU_CTRL_ABORT_EN
    run(2'b10, 6'b011000, 5);
    drive(1'b1, 1'b1, 2'b10, 6'b011000, 1'b1);
    drive(1'b1, 1'b0, 2'b00, 6'b0, 1'b1);
    drive(1'b1, 1'b0, 2'b00, 6'b0, 1'b0);
`endif
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, 9)],
            ($urandom_range(0, 29) == 0));
    drive(1'b1, 1'b0, 2'b00, 6'b0, 1'b0);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("hilo_pulse_count", dut_hilo_total, m_hilo_total);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
